// File: rtl/scd.sv
// EBOX shift-count/exponent datapath: SCAD adder, SC/FE registers, ARMM merge bits, shift-loop sequencer.
// Optional macro SCD_OVF_DETECT_EN adds the sticky SCAD signed-overflow flag SCD_SCADovf.
module scd #(
    parameter int SC_W     = 10,
    parameter int MAX_LOOP = 1023
) (
    input  logic              eboxClk,
    input  logic              eboxReset_n,
    input  logic [2:0]        CRAM_SCAD,
    input  logic [2:0]        CRAM_SCADA,
    input  logic              CRAM_SCADA_EN,
    input  logic [1:0]        CRAM_SCADB,
    input  logic              CRAM_SC,
    input  logic              CRAM_FE,
    input  logic [1:0]        CRAM_ARMM,
    input  logic [8:0]        CRAM_MAGIC,
    input  logic [0:35]       EDP_AR,
    input  logic              CTL_SCstart,
    output logic [0:SC_W-1]   SCD_SC,
    output logic [0:SC_W-1]   SCD_FE,
    output logic [0:SC_W-1]   SCD_SCAD,
    output logic              SCD_SCADsign,
    output logic [0:8]        SCD_ARMMupper,
    output logic [0:4]        SCD_ARMMlower,
    output logic              SCD_shiftStep,
    output logic              SCD_loopDone,
    output logic              SCD_loopErr
`ifdef SCD_OVF_DETECT_EN
    ,output logic             SCD_SCADovf
`endif
);

    localparam int CNT_W = $clog2(MAX_LOOP + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state, w_state_nxt;
    logic [0:SC_W-1]  r_sc, r_fe, w_sc_nxt, w_fe_nxt;
    logic [CNT_W-1:0] r_steps, w_steps_nxt;
    logic             r_err, w_err_nxt;

    logic [0:SC_W-1]  w_a, w_b, w_x, w_sum, w_scad;
    logic             w_cin, w_arith;

    // AR bits 12-35 are not used by this block.
    logic w_unused;
    assign w_unused = ^EDP_AR[12:35];

    always_comb begin
        w_a = '0;
        if (!CRAM_SCADA_EN) begin
            case (CRAM_SCADA)
                3'd0:    w_a = r_fe;
                3'd1:    w_a = SC_W'(EDP_AR[0:5]);
                3'd2:    w_a = SC_W'(EDP_AR[1:8] ^ {8{EDP_AR[0]}});
                3'd3:    w_a = SC_W'(CRAM_MAGIC);
                default: w_a = '0;
            endcase
        end
    end

    always_comb begin
        case (CRAM_SCADB)
            2'd0:    w_b = r_sc;
            2'd1:    w_b = SC_W'(EDP_AR[6:11]);
            2'd2:    w_b = SC_W'(EDP_AR[0:8]);
            default: w_b = SC_W'(CRAM_MAGIC);
        endcase
    end

    // Functions 1-5 all run through one adder A + X + cin so overflow is judged uniformly.
    always_comb begin
        w_x     = '0;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        case (CRAM_SCAD)
            3'd1:    w_x = ~w_b;
            3'd2:    w_x = w_b;
            3'd3:    w_x = '1;
            3'd4:    w_cin = 1'b1;
            3'd5:    begin w_x = ~w_b; w_cin = 1'b1; end
            default: w_arith = 1'b0;
        endcase
    end

    assign w_sum = w_a + w_x + SC_W'(w_cin);

    always_comb begin
        case (CRAM_SCAD)
            3'd0:    w_scad = w_a;
            3'd6:    w_scad = w_a | w_b;
            3'd7:    w_scad = w_a & w_b;
            default: w_scad = w_sum;
        endcase
    end

    always_comb begin
        SCD_ARMMlower = '0;
        case (CRAM_ARMM)
            2'd0: SCD_ARMMupper = CRAM_MAGIC;
            2'd1: SCD_ARMMupper = {9{EDP_AR[0]}};
            2'd2: begin
                SCD_ARMMupper = w_scad[SC_W-9:SC_W-1];
                SCD_ARMMlower = w_scad[SC_W-5:SC_W-1];
            end
            default: SCD_ARMMupper = {EDP_AR[0], w_scad[SC_W-8:SC_W-1]};
        endcase
    end

    // Loop sequencer; a CRAM_SC load in IDLE is applied before the sign test at start.
    always_comb begin
        w_state_nxt = r_state;
        w_sc_nxt    = CRAM_SC ? w_scad : r_sc;
        w_fe_nxt    = CRAM_FE ? w_scad : r_fe;
        w_steps_nxt = r_steps;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (CTL_SCstart) begin
                    w_steps_nxt = '0;
                    w_state_nxt = w_sc_nxt[0] ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (CRAM_SC) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_sc_nxt    = r_sc - SC_W'(1);
                    w_steps_nxt = r_steps + CNT_W'(1);
                    if (w_steps_nxt >= CNT_W'(MAX_LOOP))
                        w_err_nxt = 1'b1;
                    if (r_sc == '0 || w_steps_nxt >= CNT_W'(MAX_LOOP))
                        w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            r_state <= S_IDLE;
            r_sc    <= '0;
            r_fe    <= '0;
            r_steps <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sc    <= w_sc_nxt;
            r_fe    <= w_fe_nxt;
            r_steps <= w_steps_nxt;
            r_err   <= w_err_nxt;
        end
    end

`ifdef SCD_OVF_DETECT_EN
    logic w_ovf, r_ovf;
    assign w_ovf = w_arith && (w_a[0] == w_x[0]) && (w_sum[0] != w_a[0]);

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n)
            r_ovf <= 1'b0;
        else if (CRAM_SCAD == 3'd0 && CRAM_SC)
            r_ovf <= 1'b0;
        else if (w_ovf && (CRAM_SC || CRAM_FE))
            r_ovf <= 1'b1;
    end
    assign SCD_SCADovf = r_ovf;
`endif

    assign SCD_SC        = r_sc;
    assign SCD_FE        = r_fe;
    assign SCD_SCAD      = w_scad;
    assign SCD_SCADsign  = w_scad[0];
    assign SCD_shiftStep = (r_state == S_RUN);
    assign SCD_loopDone  = (r_state == S_DONE);
    assign SCD_loopErr   = r_err;

endmodule

// File: tb/tb_scd.sv
// Directed scoreboard bench for scd: expected values are queued as stimulus is applied and popped at each sample.
module tb_scd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  scad_f, scada;
    logic        scada_en, cram_sc, cram_fe, start;
    logic [1:0]  scadb, armm;
    logic [8:0]  magic;
    logic [0:35] ar;
    logic [0:9]  sc, fe, scad;
    logic        sign, step, done, err;
    logic [0:8]  up;
    logic [0:4]  low;
`ifdef SCD_OVF_DETECT_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct { string tag; logic [35:0] val; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    scd dut (
        .eboxClk(clk), .eboxReset_n(rst_n),
        .CRAM_SCAD(scad_f), .CRAM_SCADA(scada), .CRAM_SCADA_EN(scada_en), .CRAM_SCADB(scadb),
        .CRAM_SC(cram_sc), .CRAM_FE(cram_fe), .CRAM_ARMM(armm), .CRAM_MAGIC(magic),
        .EDP_AR(ar), .CTL_SCstart(start),
        .SCD_SC(sc), .SCD_FE(fe), .SCD_SCAD(scad), .SCD_SCADsign(sign),
        .SCD_ARMMupper(up), .SCD_ARMMlower(low),
        .SCD_shiftStep(step), .SCD_loopDone(done), .SCD_loopErr(err)
`ifdef SCD_OVF_DETECT_EN
        ,.SCD_SCADovf(ovf)
`endif
    );

    task automatic expect_val(input string tag, input logic [35:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [35:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic ctl_idle();
        scad_f = 3'd0; scada = 3'd0; scada_en = 1'b0; scadb = 2'd0;
        cram_sc = 1'b0; cram_fe = 1'b0; armm = 2'd0; magic = 9'd0;
        ar = '0; start = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_sc(input logic [8:0] v);
        ctl_idle();
        scada = 3'd3; magic = v; cram_sc = 1'b1;
        cyc();
        ctl_idle();
    endtask

    initial begin
        int n;
        ctl_idle();
        #3;
        expect_val("rst_sc", 36'h0);   check(sc);
        expect_val("rst_fe", 36'h0);   check(fe);
        expect_val("rst_step", 36'h0); check(step);
        expect_val("rst_done", 36'h0); check(done);
        expect_val("rst_err", 36'h0);  check(err);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload SC and FE with 155, then pull reset mid-cycle.
        scada = 3'd3; magic = 9'h155; cram_sc = 1'b1; cram_fe = 1'b1;
        #1 expect_val("pre_scad", 36'h155); check(scad);
        cyc();
        expect_val("pre_sc", 36'h155); check(sc);
        expect_val("pre_fe", 36'h155); check(fe);
        #2 rst_n = 1'b0;
        #1 expect_val("async_sc", 36'h0); check(sc);
        expect_val("async_fe", 36'h0); check(fe);
        expect_val("async_err", 36'h0); check(err);
        ctl_idle();
        #1 rst_n = 1'b1;
        @(negedge clk);

        // SCAD arithmetic and logic functions.
        scada = 3'd3; scadb = 2'd3; magic = 9'h123; scad_f = 3'd2; cram_sc = 1'b1;
        #1 expect_val("add_scad", 36'h246); check(scad);
        cyc();
        expect_val("add_sc", 36'h246); check(sc);
        ctl_idle();
        scad_f = 3'd1;
        #1 expect_val("amb1_scad", 36'h1B9); check(scad);
        expect_val("amb1_sign", 36'h0); check(sign);
        scad_f = 3'd5;
        #1 expect_val("amb_scad", 36'h1BA); check(scad);
        scada = 3'd3; magic = 9'h0F0; scad_f = 3'd6;
        #1 expect_val("or_scad", 36'h2F6); check(scad);
        expect_val("or_sign", 36'h1); check(sign);
        scad_f = 3'd7;
        #1 expect_val("and_scad", 36'h040); check(scad);
        magic = 9'h000; scad_f = 3'd3;
        #1 expect_val("am1_scad", 36'h3FF); check(scad);
        magic = 9'h1FF; scad_f = 3'd4;
        #1 expect_val("ap1_scad", 36'h200); check(scad);
        scada_en = 1'b1; scad_f = 3'd0;
        #1 expect_val("aen_scad", 36'h000); check(scad);
        ctl_idle();

        // Exponent extraction and ARMM merge bits.
        ar = 36'h7C0000000; scada = 3'd2; armm = 2'd2;
        #1 expect_val("exp_up", 36'h0F8); check(up);
        expect_val("exp_low", 36'h18); check(low);
        ar = 36'hFC0000000;
        #1 expect_val("nexp_up", 36'h007); check(up);
        expect_val("nexp_low", 36'h07); check(low);
        armm = 2'd3;
        #1 expect_val("armm3_up", 36'h107); check(up);
        expect_val("armm3_low", 36'h00); check(low);
        armm = 2'd1;
        #1 expect_val("armm1_up", 36'h1FF); check(up);
        armm = 2'd0; magic = 9'h0A5;
        #1 expect_val("armm0_up", 36'h0A5); check(up);
        ctl_idle();

        // Shift loop from SC = 3: four steps, SC ends at 3FF, one done pulse.
        load_sc(9'd3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (step && n < 40) begin
            n++;
            cyc();
        end
        expect_val("loop_steps", 36'd4); check(36'(n));
        expect_val("loop_sc", 36'h3FF); check(sc);
        expect_val("loop_done", 36'h1); check(done);
        cyc();
        expect_val("loop_done_end", 36'h0); check(done);
        expect_val("loop_step_end", 36'h0); check(step);

        // Negative SC at start goes straight to DONE.
        start = 1'b1;
        cyc();
        start = 1'b0;
        expect_val("neg_step", 36'h0); check(step);
        expect_val("neg_done", 36'h1); check(done);
        cyc();

        // Abort in the second RUN cycle; start during RUN is ignored.
        load_sc(9'd5);
        start = 1'b1;
        cyc();
        expect_val("ab_run1", 36'h1); check(step);
        cyc();
        expect_val("ab_sc2", 36'h004); check(sc);
        start = 1'b0; scada = 3'd3; magic = 9'h010; cram_sc = 1'b1;
        cyc();
        ctl_idle();
        expect_val("ab_sc", 36'h010); check(sc);
        expect_val("ab_step", 36'h0); check(step);
        expect_val("ab_done", 36'h0); check(done);
        cyc();
        expect_val("ab_done2", 36'h0); check(done);

        // Reset mid-loop returns to IDLE without a done pulse.
        load_sc(9'h100);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        #1 expect_val("mrst_step", 36'h0); check(step);
        expect_val("mrst_sc", 36'h0); check(sc);
        #1 rst_n = 1'b1;
        @(negedge clk);
        expect_val("mrst_done", 36'h0); check(done);
        expect_val("mrst_err", 36'h0); check(err);

`ifdef SCD_OVF_DETECT_EN
        expect_val("ovf_rst", 36'h0); check(ovf);
        scada = 3'd3; magic = 9'h1FF; scadb = 2'd1; ar = 36'h001000000; scad_f = 3'd2; cram_sc = 1'b1;
        cyc();
        expect_val("ovf_set", 36'h1); check(ovf);
        cram_sc = 1'b0; scad_f = 3'd0;
        cyc();
        expect_val("ovf_hold", 36'h1); check(ovf);
        ctl_idle();
        scad_f = 3'd4; cram_fe = 1'b1;
        cyc();
        expect_val("ovf_sticky", 36'h1); check(ovf);
        ctl_idle();
        cram_sc = 1'b1;
        cyc();
        expect_val("ovf_clr", 36'h0); check(ovf);
        ctl_idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scd.md
Name: scd

Overview:
- Shift-count/exponent datapath of the EBOX, directly upstream of edp.
- Computes SCAD (10-bit adder) from FE/AR fields/magic and holds the SC and FE registers.
- Drives the ARMM bits that edp merges into AR via SCD_ARMMupper/SCD_ARMMlower.
- Contains a shift-loop sequencer that counts SC down, one step per cycle, for multi-cycle shifts/normalize.

Parameters:
SC_W, 10, width of SC, FE and SCAD (two's complement)
MAX_LOOP, 1023, loop-step limit before SCD_loopErr asserts

Ports:
eboxClk  input  1  EBOX clock, all state on posedge
eboxReset_n  input  1  asynchronous active-low reset
CRAM_SCAD  input  3  SCAD function
CRAM_SCADA  input  3  SCADA select
CRAM_SCADA_EN  input  1  1 = force A operand to 0
CRAM_SCADB  input  2  SCADB select
CRAM_SC  input  1  1 = load SC from SCAD
CRAM_FE  input  1  1 = load FE from SCAD
CRAM_ARMM  input  2  ARMM source select
CRAM_MAGIC  input  9  magic-number field
EDP_AR  input  36  AR from edp, bit 0 = MSB
CTL_SCstart  input  1  start shift loop (pulse)
SCD_SC  output  10  SC register
SCD_FE  output  10  FE register
SCD_SCAD  output  10  combinational SCAD result
SCD_SCADsign  output  1  SCAD[0]
SCD_ARMMupper  output  9  to edp AR bits 0-8
SCD_ARMMlower  output  5  to edp AR bits 13-17
SCD_shiftStep  output  1  high each cycle loop is stepping
SCD_loopDone  output  1  one-cycle pulse at loop end
SCD_loopErr  output  1  sticky, step limit exceeded

Behaviour:
- Reset (async, eboxReset_n low):
  - SC = 0, FE = 0, FSM = IDLE, loop step counter = 0.
  - SCD_shiftStep = SCD_loopDone = SCD_loopErr = 0.
- SCADA operand (CRAM_SCADA_EN = 1 forces A = 0):
  - 0 = FE
  - 1 = {4'b0, AR[0:5]}
  - 2 = exponent {2'b0, AR[1:8] ^ {8{AR[0]}}}
  - 3 = {1'b0, MAGIC}
  - 4-7 = 0
- SCADB operand:
  - 0 = SC
  - 1 = {4'b0, AR[6:11]}
  - 2 = {1'b0, AR[0:8]}
  - 3 = {1'b0, MAGIC}
- SCAD function:
  - 0 = A
  - 1 = A-B-1
  - 2 = A+B
  - 3 = A-1
  - 4 = A+1
  - 5 = A-B
  - 6 = A|B
  - 7 = A&B
  - All arithmetic is mod 2^10; no carry-out is kept.
- ARMM (combinational):
  - Upper: CRAM_ARMM 0 = MAGIC; 1 = {9{AR[0]}}; 2 = SCAD[1:9]; 3 = {AR[0], SCAD[2:9]}.
  - Lower = SCAD[5:9] when CRAM_ARMM = 2, else 0.
- IDLE state:
  - CRAM_SC = 1 loads SC ← SCAD at posedge; CRAM_FE = 1 loads FE ← SCAD. Both may load in the same cycle.
  - CTL_SCstart = 1 goes to RUN. A simultaneous CRAM_SC load is applied first, so the loop uses the new SC.
  - If SC[0] = 1 (negative) at start, go straight to DONE with zero steps.
- RUN state:
  - Each cycle: SCD_shiftStep = 1, SC ← SC-1, step counter +1.
  - When SC = 0 is decremented to 10'h3FF, go to DONE.
  - Total steps = SC_start + 1 for SC_start in 0..511.
  - CRAM_SC = 1 in RUN aborts the loop: SC ← SCAD, go to IDLE, no done pulse.
  - CRAM_FE loads are honoured in RUN.
  - CTL_SCstart in RUN is ignored.
  - If the step counter reaches MAX_LOOP: set SCD_loopErr, go to DONE.
- DONE state:
  - SCD_loopDone = 1 for exactly one cycle, then IDLE.
  - CTL_SCstart in DONE is ignored.
- SCD_loopErr clears only on reset.
- A reset mid-loop returns to IDLE immediately; no done pulse.

Optional Feature:
- Macro: SCD_OVF_DETECT_EN.
- Defined:
  - Adds output SCD_SCADovf (1 bit).
  - Sticky; set when a SCAD function 1-5 that loads SC or FE has signed 10-bit overflow.
  - Overflow = operand signs equal and result sign differs (add), or the subtract-equivalent condition.
  - Cleared by reset or by CRAM_SCAD = 0 with CRAM_SC = 1.
- Undefined: the port is absent; no overflow logic.

Test Plan:
- Reset with SC = FE = 10'h155 preloaded -> eboxReset_n low mid-cycle clears SC, FE and all flags asynchronously.
- CRAM_SCADA = 3, MAGIC = 9'h123, CRAM_SCADB = 3, CRAM_SCAD = 2, CRAM_SC = 1 -> SCD_SC = 10'h246; then SCAD = 1 with FE source (FE = 0) and SC = 10'h246 -> SCAD = 10'h1B9.
- AR = 36'h_7C0000000 (AR[0] = 0, exp 8'hF8), SCADA = 2, SCAD = 0, CRAM_ARMM = 2 -> SCD_ARMMupper = 9'h0F8; with AR[0] = 1 the exponent is inverted -> 9'h007.
- SC = 3, CTL_SCstart -> SCD_shiftStep high 4 cycles, SC ends at 10'h3FF, SCD_loopDone pulses 1 cycle later.
- SC = 5, start, CRAM_SC = 1 with SCAD = 10'h010 in the 2nd RUN cycle -> loop aborts, SC = 10'h010, no loopDone; start in RUN ignored.
- With SCD_OVF_DETECT_EN: A = 10'h1FF, B = 1, SCAD = 2, SC load -> SCD_SCADovf = 1 and stays set until cleared.
